// File: rtl/arm_verilog_pkg.sv
// rtl/arm_verilog_pkg.sv - shared state encoding and default sizing for the serial frame sender
package arm_verilog_pkg;

  localparam int A_W_DEF = 7;
  localparam int D_W_DEF = 8;
  localparam int DIV_DEF = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_LO = 2'd1,
    BIT_HI = 2'd2
  } state_e;

endpackage

// File: rtl/arm_verilog_if.sv
// rtl/arm_verilog_if.sv - frame request inputs and serial outputs of the sender
interface arm_verilog_if
  import arm_verilog_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int D_W = D_W_DEF
);
  logic [D_W-1:0] D;
  logic [A_W-1:0] A;
  logic           Go;
  logic           OutD;
  logic           OutC;

  modport master (output D, output A, output Go, input OutD, input OutC);
  modport slave  (input D, input A, input Go, output OutD, output OutC);
endinterface

// File: rtl/arm_verilog_shifter.sv
// rtl/arm_verilog_shifter.sv - parallel-load MSB-first shift register, MSB is the serial bit
module arm_verilog_shifter #(
  parameter int W = 15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);
  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = {data_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb_o = data_q[W-1];
endmodule

// File: rtl/arm_verilog.sv
// rtl/arm_verilog.sv - serialises {A,D} MSB first on OutD with a divided clock on OutC
module arm_verilog
  import arm_verilog_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int D_W = D_W_DEF,
  parameter int DIV = DIV_DEF
) (
  output logic           OutD,
  output logic           OutC,
  input  logic [D_W-1:0] D,
  input  logic [A_W-1:0] A,
  input  logic           Go,
  input  logic           clk_in,
  input  logic           reset_n
);
  localparam int FW    = A_W + D_W;
  localparam int CNT_W = ($clog2(FW) > 4) ? $clog2(FW) : 4;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FW - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic             outc_q, outc_d;
  logic             load, shift;

  // The shift after the final bit empties the register, so OutD drops to 0 on return to IDLE.
  arm_verilog_shifter #(.W(FW)) u_shifter (
    .clk_i  (clk_in),
    .rst_i  (reset_n),
    .load_i (load),
    .shift_i(shift),
    .data_i ({A, D}),
    .msb_o  (OutD)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    outc_d  = outc_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        outc_d = 1'b0;
        div_d  = '0;
        bit_d  = '0;
        if (Go) begin
          load    = 1'b1;
          state_d = BIT_LO;
        end
      end
      BIT_LO: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          outc_d  = 1'b1;
          state_d = BIT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      BIT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          outc_d = 1'b0;
          shift  = 1'b1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = BIT_LO;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      outc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      outc_q  <= outc_d;
    end
  end

  assign OutC = outc_q;
endmodule

// File: tb/tb_arm_verilog.sv
// tb/tb_arm_verilog.sv - scoreboard bench for arm_verilog with directed and random frames
module tb_arm_verilog;
  localparam int A_W = 7;
  localparam int D_W = 8;
  localparam int DIV = 1;
  localparam int FW  = A_W + D_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arm_verilog_if #(.A_W(A_W), .D_W(D_W)) bus ();

  arm_verilog #(.A_W(A_W), .D_W(D_W), .DIV(DIV)) dut (
    .OutD   (bus.OutD),
    .OutC   (bus.OutC),
    .D      (bus.D),
    .A      (bus.A),
    .Go     (bus.Go),
    .clk_in (clk),
    .reset_n(rst)
  );

  typedef struct {
    logic b;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   free_at = 0;
  int   frame_end = 0;
  bit   started = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference: an accepted frame owns the line for 30*DIV cycles; bit i is presented
  // at the OutC rise (2i+1)*DIV cycles after acceptance.
  always @(posedge clk) begin
    logic [FW-1:0] fr;
    cyc++;
    if (rst === 1'b1) begin
      q.delete();
      started   = 1;
      free_at   = cyc + 1;
      frame_end = cyc;
    end else if (started && bus.Go === 1'b1 && cyc >= free_at) begin
      fr = {bus.A, bus.D};
      for (int i = 0; i < FW; i++) begin
        exp_t e;
        e.b   = fr[FW-1-i];
        e.cyc = cyc + (2 * i + 1) * DIV;
        q.push_back(e);
      end
      free_at   = cyc + 2 * FW * DIV + 1;
      frame_end = cyc + 2 * FW * DIV;
    end
  end

  logic prev_c;
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (bus.OutC === 1'b1 && prev_c !== 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_outc cyc=%0d got OutC rise required none", cyc);
        end else begin
          e = q.pop_front();
          if (bus.OutD !== e.b || cyc != e.cyc) begin
            errors++;
            $display("FAIL bit_at_rise got OutD=%b cyc=%0d required OutD=%b cyc=%0d",
                     bus.OutD, cyc, e.b, e.cyc);
          end
        end
      end
      if (cyc >= frame_end) begin
        checks++;
        if (bus.OutD !== 1'b0 || bus.OutC !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs cyc=%0d got OutD=%b OutC=%b required 0 0",
                   cyc, bus.OutD, bus.OutC);
        end
      end
    end
    prev_c = bus.OutC;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic one_frame(input logic [A_W-1:0] a, input logic [D_W-1:0] d);
    bus.A  = a;
    bus.D  = d;
    bus.Go = 1'b1;
    tick();
    bus.Go = 1'b0;
    repeat (35) tick();
  endtask

  initial begin
    rst    = 1'b1;
    bus.Go = 1'b1;
    bus.A  = '0;
    bus.D  = '0;
    repeat (2) tick();
    rst    = 1'b0;
    bus.Go = 1'b0;
    repeat (3) tick();

    one_frame(7'h7F, 8'hFF);
    one_frame(7'h55, 8'hA5);

    // Inputs change and Go pulses while a frame is in flight.
    bus.A  = 7'h7F;
    bus.D  = 8'hFF;
    bus.Go = 1'b1;
    tick();
    bus.Go = 1'b0;
    bus.A  = '0;
    bus.D  = '0;
    repeat (9) tick();
    bus.Go = 1'b1;
    tick();
    bus.Go = 1'b0;
    repeat (30) tick();

    bus.A  = 7'h01;
    bus.D  = 8'h80;
    bus.Go = 1'b1;
    repeat (70) tick();
    bus.Go = 1'b0;
    repeat (35) tick();

    // Reset lands mid-frame.
    bus.A  = 7'h55;
    bus.D  = 8'hA5;
    bus.Go = 1'b1;
    tick();
    bus.Go = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (35) tick();

    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 79) == 0);
      bus.Go = ($urandom_range(0, 3) == 0);
      bus.A  = A_W'($urandom);
      bus.D  = D_W'($urandom);
      tick();
    end
    rst    = 1'b0;
    bus.Go = 1'b0;
    repeat (40) tick();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_bits got %0d pending required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
